fp_div_core: RTL and testbench
==============================

Name: fp_div_core

Overview:
- Sequential single-precision IEEE-754 divide stage, directly downstream of the special-case checker.
- For operands the checker has already resolved (NaN, inf, zero, divide-by-zero), it forwards the checker's quotient and exception code unchanged.
- For normal operands it runs a restoring radix-2 mantissa divide, subtracts exponents, normalizes and rounds to nearest-even.
- Consumer-side valid/ready handshake on the output.

Parameters:
- EXP_BIAS, 127, exponent bias added back after exponent subtraction.
- QBITS, 27, quotient bits produced by the iterative divider (24 mantissa + guard + extra + normalization bit).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and special-case result valid.
- in_ready  out  1  block can accept a new division.
- InputA  in  32  dividend, IEEE-754 single.
- InputB  in  32  divisor, IEEE-754 single.
- special_valid  in  1  checker resolved this operation; use special_result/special_exc.
- special_result  in  32  quotient from checker.
- special_exc  in  2  exception code from checker.
- out_valid  out  1  AbyB/EXCEPTION valid.
- out_ready  in  1  consumer accepts result.
- AbyB  out  32  quotient.
- EXCEPTION  out  2  00 divide-by-zero, 01 none, 10 overflow/underflow, 11 invalid.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, AbyB=0, EXCEPTION=01, all internal registers 0.
- Clock and reset: one clock; reset is synchronous and active-high. Reset has priority over everything, including mid-DIVIDE and a held DONE; any in-flight operation is discarded with no output.
- State IDLE (in_ready=1)
  - Acceptance edge is when in_valid=1.
  - If special_valid=1: latch special_result into AbyB and special_exc into EXCEPTION, go to DONE. out_valid is high 1 cycle after acceptance.
  - Otherwise latch:
    - sign = A[31]^B[31]
    - mA = {1,A[22:0]}, mB = {1,B[22:0]}
    - exp = {2'b0,A[30:23]} - {2'b0,B[30:23]}, 10-bit signed
    - rem = mA (25 bits), q = 0, cnt = QBITS-1
    - go to DIVIDE.
- State DIVIDE (in_ready=0)
  - Each cycle: if rem >= mB then q[cnt]=1 and rem = rem - mB; then rem = rem<<1; cnt decrements.
  - After the step with cnt==0, go to NORM. DIVIDE lasts exactly 27 cycles.
  - Result: q = floor(mA * 2^26 / mB), so either q[26]=1 or q[25]=1.
- State NORM
  - If q[26]: man = q[26:3], g = q[2], s = |q[1:0] | (rem!=0), exp = exp + EXP_BIAS.
  - Else: man = q[25:2], g = q[1], s = q[0] | (rem!=0), exp = exp + EXP_BIAS - 1.
- State ROUND
  - Round up when g & (s | man[0]).
  - If man rounds from 0xFFFFFF, set man = 0x800000 and exp = exp+1.
  - exp >= 255: AbyB = {sign, 8'hFF, 23'b0}, EXCEPTION = 10.
  - exp <= 0: AbyB = {sign, 31'b0} (flush, no denormal output), EXCEPTION = 10.
  - Else: AbyB = {sign, exp[7:0], man[22:0]}, EXCEPTION = 01.
  - Go to DONE.
- State DONE
  - out_valid=1; AbyB and EXCEPTION held stable while out_ready=0.
  - On out_valid & out_ready, out_valid drops next cycle and the block returns to IDLE.
  - No new input is accepted in DONE (in_ready=0), so there is no same-cycle accept-and-retire.
- Latency, normal path: out_valid asserts 29 cycles after the acceptance edge (27 DIVIDE + NORM + ROUND).
- in_valid asserted outside IDLE is ignored; the upstream stage must hold its inputs until in_ready=1.
- Inputs with exponent 0 (zero or denormal) are always flagged by the checker via special_valid. This block does not handle them.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0), special_valid=0 -> after 29 cycles AbyB=0x40400000, EXCEPTION=01.
- 0x3F800000 / 0x40400000 (1/3) -> AbyB=0x3EAAAAAB (rounded up via guard/sticky), EXCEPTION=01; negating A gives 0xBEAAAAAB.
- 0x7F000000 / 0x3E800000 (2^127/0.25) -> AbyB=0x7F800000, EXCEPTION=10; 0x00800000 / 0x4B000000 -> AbyB=0x00000000, EXCEPTION=10.
- special_valid=1, special_result=0xFFC00000, special_exc=11 -> out_valid 1 cycle after acceptance, AbyB=0xFFC00000, EXCEPTION=11; repeat with special_exc=00.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, AbyB and EXCEPTION stable, in_ready=0; raise out_ready -> in_ready=1 the next cycle.
- Assert reset at DIVIDE cycle 12 -> next cycle state IDLE, out_valid=0, in_ready=1, EXCEPTION=01. A fresh 6.0/2.0 then completes correctly.

Source files
------------

// File: rtl/fp_div_core.sv
// Sequential IEEE-754 single-precision divide stage: forwards checker-resolved
// results, otherwise restoring radix-2 mantissa divide, normalize, round-to-nearest-even.
module fp_div_core #(
    parameter int EXP_BIAS = 127,
    parameter int QBITS    = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    input  logic        special_valid,
    input  logic [31:0] special_result,
    input  logic [1:0]  special_exc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] AbyB,
    output logic [1:0]  EXCEPTION
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIVIDE = 3'd1,
        NORM   = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             r_state, w_state_next;
    logic               r_sign;
    logic [23:0]        r_mb;
    logic [9:0]         r_exp;
    logic [24:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [4:0]         r_cnt;
    logic [23:0]        r_man;
    logic               r_g;
    logic               r_s;
    logic [31:0]        r_abyb;
    logic [1:0]         r_exc;

    logic               w_ge;
    logic [24:0]        w_rem_sub;
    logic [24:0]        w_man_inc;
    logic               w_round_up;
    logic               w_carry;
    logic [23:0]        w_man_fin;
    logic [9:0]         w_exp_fin;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign AbyB      = r_abyb;
    assign EXCEPTION = r_exc;

    // One restoring step: the remainder never exceeds 2*mB, so 25 bits suffice.
    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

    assign w_man_inc  = {1'b0, r_man} + 25'd1;
    assign w_round_up = r_g & (r_s | r_man[0]);
    assign w_carry    = w_round_up & w_man_inc[24];
    assign w_man_fin  = w_carry ? 24'h800000 : (w_round_up ? w_man_inc[23:0] : r_man);
    assign w_exp_fin  = r_exp + {9'd0, w_carry};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = special_valid ? DONE : DIVIDE;
            DIVIDE:  if (r_cnt == 5'd0) w_state_next = NORM;
            NORM:    w_state_next = ROUND;
            ROUND:   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_mb   <= '0;
            r_exp  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_man  <= '0;
            r_g    <= 1'b0;
            r_s    <= 1'b0;
            r_abyb <= '0;
            r_exc  <= 2'b01;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && special_valid) begin
                        r_abyb <= special_result;
                        r_exc  <= special_exc;
                    end else if (in_valid) begin
                        r_sign <= InputA[31] ^ InputB[31];
                        r_mb   <= {1'b1, InputB[22:0]};
                        r_exp  <= {2'b00, InputA[30:23]} - {2'b00, InputB[30:23]};
                        r_rem  <= {2'b01, InputA[22:0]};
                        r_q    <= '0;
                        r_cnt  <= 5'(QBITS - 1);
                    end
                end
                DIVIDE: begin
                    r_q[r_cnt] <= w_ge;
                    r_rem      <= {w_rem_sub[23:0], 1'b0};
                    r_cnt      <= r_cnt - 5'd1;
                end
                NORM: begin
                    // Quotient lies in [0.5, 2) scaled by 2^26; pick the leading one.
                    if (r_q[26]) begin
                        r_man <= r_q[26:3];
                        r_g   <= r_q[2];
                        r_s   <= (|r_q[1:0]) | (r_rem != '0);
                        r_exp <= r_exp + 10'(EXP_BIAS);
                    end else begin
                        r_man <= r_q[25:2];
                        r_g   <= r_q[1];
                        r_s   <= r_q[0] | (r_rem != '0);
                        r_exp <= r_exp + 10'(EXP_BIAS - 1);
                    end
                end
                ROUND: begin
                    r_man <= w_man_fin;
                    r_exp <= w_exp_fin;
                    if ($signed(w_exp_fin) >= 10'sd255) begin
                        r_abyb <= {r_sign, 8'hFF, 23'd0};
                        r_exc  <= 2'b10;
                    end else if ($signed(w_exp_fin) <= 10'sd0) begin
                        r_abyb <= {r_sign, 31'd0};
                        r_exc  <= 2'b10;
                    end else begin
                        r_abyb <= {r_sign, w_exp_fin[7:0], w_man_fin[22:0]};
                        r_exc  <= 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_core.sv
// Directed bench for fp_div_core: hand-computed quotients, latency, handshake and reset.
module tb_fp_div_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] InputA;
    logic [31:0] InputB;
    logic        special_valid;
    logic [31:0] special_result;
    logic [1:0]  special_exc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] AbyB;
    logic [1:0]  EXCEPTION;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_div_core dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .InputA         (InputA),
        .InputB         (InputB),
        .special_valid  (special_valid),
        .special_result (special_result),
        .special_exc    (special_exc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .AbyB           (AbyB),
        .EXCEPTION      (EXCEPTION)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Latency counts clock edges after the acceptance edge until out_valid is seen.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sv, input logic [31:0] sr, input logic [1:0] se,
                         input logic [31:0] exp_q, input logic [1:0] exp_e,
                         input int exp_lat, input logic retire);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        InputA = a; InputB = b; special_valid = sv; special_result = sr; special_exc = se;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".AbyB"}, AbyB, exp_q);
        check({tag, ".EXCEPTION"}, {30'd0, EXCEPTION}, {30'd0, exp_e});
        $display("[TB] %s A=%h B=%h -> AbyB=%h EXC=%b lat=%0d", tag, a, b, AbyB, EXCEPTION, lat);
        if (retire) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            check({tag, ".retire_out_valid"}, {31'd0, out_valid}, 32'd0);
            check({tag, ".retire_in_ready"}, {31'd0, in_ready}, 32'd1);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; InputA = '0; InputB = '0;
        special_valid = 1'b0; special_result = '0; special_exc = 2'b00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.AbyB", AbyB, 32'd0);
        check("rst.EXCEPTION", {30'd0, EXCEPTION}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        do_op("6/2",      32'h40C00000, 32'h40000000, 1'b0, 32'd0, 2'b00, 32'h40400000, 2'b01, 29, 1'b1);
        do_op("1/3",      32'h3F800000, 32'h40400000, 1'b0, 32'd0, 2'b00, 32'h3EAAAAAB, 2'b01, 29, 1'b1);
        do_op("-1/3",     32'hBF800000, 32'h40400000, 1'b0, 32'd0, 2'b00, 32'hBEAAAAAB, 2'b01, 29, 1'b1);
        do_op("ovf",      32'h7F000000, 32'h3E800000, 1'b0, 32'd0, 2'b00, 32'h7F800000, 2'b10, 29, 1'b1);
        do_op("unf",      32'h00800000, 32'h4B000000, 1'b0, 32'd0, 2'b00, 32'h00000000, 2'b10, 29, 1'b1);
        do_op("spec_inv", 32'h7FC00000, 32'h3F800000, 1'b1, 32'hFFC00000, 2'b11, 32'hFFC00000, 2'b11, 0, 1'b1);
        do_op("spec_dbz", 32'h3F800000, 32'h00000000, 1'b1, 32'hFFC00000, 2'b00, 32'hFFC00000, 2'b00, 0, 1'b1);

        // Back-pressure: result must stay frozen while the consumer stalls.
        do_op("hold", 32'h40C00000, 32'h40000000, 1'b0, 32'd0, 2'b00, 32'h40400000, 2'b01, 29, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold.stable", {out_valid, in_ready, EXCEPTION, AbyB[27:0]},
                  {1'b1, 1'b0, 2'b01, 28'h0400000});
        end
        check("hold.AbyB_top", {28'd0, AbyB[31:28]}, 32'h4);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold.release_in_ready", {31'd0, in_ready}, 32'd1);
        check("hold.release_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        $display("[TB] hold released after 10 stalled cycles");

        // Reset in the middle of DIVIDE discards the operation.
        @(negedge clk);
        InputA = 32'h3F800000; InputB = 32'h40400000; special_valid = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.EXCEPTION", {30'd0, EXCEPTION}, 32'd1);
        check("midrst.AbyB", AbyB, 32'd0);
        $display("[TB] reset asserted during DIVIDE");
        @(negedge clk);
        reset = 1'b0;
        do_op("post_rst", 32'h40C00000, 32'h40000000, 1'b0, 32'd0, 2'b00, 32'h40400000, 2'b01, 29, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
